// File: rtl/door_pkg.sv
// Door state encodings shared by the door controller and the car movement/emergency blocks.
package door_pkg;
    localparam logic [1:0] DOOR_ENC_CLOSED  = 2'b00;
    localparam logic [1:0] DOOR_ENC_OPENING = 2'b01;
    localparam logic [1:0] DOOR_ENC_OPEN    = 2'b10;
    localparam logic [1:0] DOOR_ENC_CLOSING = 2'b11;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = DOOR_ENC_CLOSED,
        DOOR_OPENING = DOOR_ENC_OPENING,
        DOOR_OPEN    = DOOR_ENC_OPEN,
        DOOR_CLOSING = DOOR_ENC_CLOSING
    } door_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/door_timer.sv
// Phase down-counter: load has priority over decrement, holds at zero instead of wrapping.
module door_timer
    import door_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/door_controller.sv
// Elevator door sequencer: CLOSED -> OPENING -> OPEN -> CLOSING with obstruction/emergency reopen.
// Each phase lasts its configured cycle count; call_clear and door_done are registered one-cycle pulses.
module door_controller
    import door_pkg::*;
#(
    parameter int N_FLOORS     = 3,
    parameter int FLOOR_W      = 2,
    parameter int OPEN_CYCLES  = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [FLOOR_W-1:0]  floor_i,
    input  logic                arrived_i,
    input  logic [N_FLOORS-1:0] call_pending_i,
    input  logic                obstruction_i,
    input  logic                emergency_stop_i,
    output logic [1:0]          door_state_o,
    output logic                hold_car_o,
    output logic [N_FLOORS-1:0] call_clear_o,
    output logic                door_done_o
);
    localparam int CNT_W = $clog2(max3(OPEN_CYCLES, DWELL_CYCLES, CLOSE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LD = CNT_W'(CLOSE_CYCLES - 1);

    door_state_e         state_q, state_d;
    logic [FLOOR_W-1:0]  svc_floor_q, svc_floor_d;
    logic [N_FLOORS-1:0] call_clear_q, call_clear_d;
    logic                door_done_q, door_done_d;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]    tmr_val;
    logic [N_FLOORS-1:0] floor_mask;
    logic                floor_ok, call_here, hold_open;

    // Out-of-range floors shift the mask to zero, so they never match a call.
    assign floor_mask = N_FLOORS'(1) << floor_i;
    assign floor_ok   = (int'(floor_i) < N_FLOORS);
    assign call_here  = floor_ok && |(call_pending_i & floor_mask);
    assign hold_open  = obstruction_i || emergency_stop_i;

    door_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        svc_floor_d  = svc_floor_q;
        call_clear_d = '0;
        door_done_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_dec      = 1'b0;
        unique case (state_q)
            DOOR_CLOSED: begin
                if (arrived_i && call_here && !emergency_stop_i) begin
                    state_d     = DOOR_OPENING;
                    svc_floor_d = floor_i;
                    tmr_load    = 1'b1;
                    tmr_val     = OPEN_LD;
                end
            end
            DOOR_OPENING: begin
                if (tmr_zero) begin
                    state_d      = DOOR_OPEN;
                    tmr_load     = 1'b1;
                    tmr_val      = DWELL_LD;
                    call_clear_d = N_FLOORS'(1) << svc_floor_q;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (hold_open) begin
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LD;
                end else if (tmr_zero) begin
                    state_d  = DOOR_CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = CLOSE_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_CLOSING: begin
                // A reopen request beats an expiring close.
                if (hold_open) begin
                    state_d  = DOOR_OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                end else if (tmr_zero) begin
                    state_d     = DOOR_CLOSED;
                    door_done_d = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= DOOR_CLOSED;
            svc_floor_q  <= '0;
            call_clear_q <= '0;
            door_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            svc_floor_q  <= svc_floor_d;
            call_clear_q <= call_clear_d;
            door_done_q  <= door_done_d;
        end
    end

    assign door_state_o = state_q;
    assign hold_car_o   = (state_q != DOOR_CLOSED);
    assign call_clear_o = call_clear_q;
    assign door_done_o  = door_done_q;
endmodule
